gate_rr_arbiter: RTL

//  Shares one registered W-bit two-input logic unit (OR/XOR/AND/NOR) among NREQ

---
 rtl/gate_rr_arbiter_if.sv | 26 ++
 rtl/gate_rr_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/gate_rr_arbiter_if.sv
// Request/result bus between the requester blocks and the shared gate unit.
// Operands and ops are packed per requester: slot i sits at [W*i +: W] / [2*i +: 2].
interface gate_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IW   = 2
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op_in;
  logic [W*NREQ-1:0] a_in;
  logic [W*NREQ-1:0] b_in;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      y_out;
  logic              busy;
  logic [IW-1:0]     grant_idx;

  modport master (
    output req, op_in, a_in, b_in,
    input  ack, y_out, busy, grant_idx
  );

  modport slave (
    input  req, op_in, a_in, b_in,
    output ack, y_out, busy, grant_idx
  );
endinterface

// File: rtl/gate_rr_arbiter.sv
// Round-robin shared two-input gate unit (OR/XOR/AND/NOR), one op in flight.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for any req; picks winner from ptr and latches it
// EXEC  | computes f(op,a,b) on the latched operands into y
// DONE  | pulses ack to the winner, advances ptr past the winner
module gate_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  gate_rr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  y_q, y_d;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  int            cand;

  logic [NREQ-1:0] ack_c;
  logic            busy_c;

  // Round-robin search starting at ptr; first requester found wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr_q) + i) % NREQ;
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(cand);
      end
    end
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
    end
  end

  // Next-state: operands are captured only in IDLE, so later input changes
  // cannot disturb the op in flight.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          gidx_d  = sel_idx;
          op_d    = bus.op_in[2*int'(sel_idx) +: 2];
          a_d     = bus.a_in[W*int'(sel_idx) +: W];
          b_d     = bus.b_in[W*int'(sel_idx) +: W];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          2'b00: y_d = a_q | b_q;
          2'b01: y_d = a_q ^ b_q;
          2'b10: y_d = a_q & b_q;
          2'b11: y_d = ~(a_q | b_q);
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: ack is a single one-hot pulse, only in DONE.
  always_comb begin
    ack_c  = '0;
    busy_c = 1'b0;
    if (state_q == S_DONE) begin
      ack_c[gidx_q] = 1'b1;
    end
    if (state_q == S_EXEC || state_q == S_DONE) begin
      busy_c = 1'b1;
    end
  end

  assign bus.ack       = ack_c;
  assign bus.busy      = busy_c;
  assign bus.y_out     = y_q;
  assign bus.grant_idx = gidx_q;

endmodule
